// File: rtl/jtframe_pkg.sv
// Shared definitions for the frame dump controller; sim monitors import the
// state type from here to decode the controller state.
package jtframe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DUMP  = 2'd2,
      DONE  = 2'd3
   } dump_state_e;

   localparam int FW_DEFAULT = 32;
   localparam int LW_DEFAULT = 16;

   function automatic logic state_is_busy(input dump_state_e s);
      return (s == ARMED) || (s == DUMP);
   endfunction

   function automatic logic state_is_dump(input dump_state_e s);
      return (s == DUMP);
   endfunction

endpackage

// File: rtl/jtframe_frame_cnt.sv
// Vertical-sync falling-edge detector and free-running frame counter.
// The counter is held at zero for the whole of a ROM download.
module jtframe_frame_cnt #(
   parameter int FW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vs,
   input  logic          downloading,
   output logic          tick,
   output logic [FW-1:0] frame_cnt
);

   logic          vs_q;
   logic [FW-1:0] cnt_q;
   logic [FW-1:0] cnt_d;

   assign tick      = vs_q & ~vs;
   assign frame_cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (downloading) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + FW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         vs_q  <= vs;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Frame-window dump sequencer: waits for a start frame, holds dump_on for a
// configured number of frames, and aborts cleanly when a ROM download begins.
//
// state | meaning
// IDLE  | waiting for arm; configuration writes accepted here only
// ARMED | armed, waiting for a tick at or past the start frame
// DUMP  | dump window open (dump_on high)
// DONE  | window finished; waits for arm to drop before re-arming
module jtframe_dump_ctrl
   import jtframe_pkg::*;
#(
   parameter int FW = 32,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vs,
   input  logic          downloading,
   input  logic          cfg_we,
   input  logic [FW-1:0] cfg_start,
   input  logic [LW-1:0] cfg_len,
   input  logic          cfg_deep,
   input  logic          arm,
   output logic [FW-1:0] frame_cnt,
   output logic          dump_on,
   output logic          dump_deep,
   output logic          dump_start,
   output logic          dump_stop,
   output logic          aborted,
   output logic          busy
);

   dump_state_e   state_q, state_d;
   logic [FW-1:0] start_q, start_d;
   logic [LW-1:0] len_q, len_d;
   logic          deep_q, deep_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          aborted_q, aborted_d;

   logic dump_on_q, dump_on_d;
   logic dump_deep_q, dump_deep_d;
   logic dump_start_q, dump_start_d;
   logic dump_stop_q, dump_stop_d;
   logic busy_q, busy_d;

   logic          tick;
   logic [FW-1:0] frame_cnt_w;

   jtframe_frame_cnt #(
      .FW (FW)
   ) u_frame_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .vs          (vs),
      .downloading (downloading),
      .tick        (tick),
      .frame_cnt   (frame_cnt_w)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         start_q      <= '0;
         len_q        <= '0;
         deep_q       <= 1'b0;
         rem_q        <= '0;
         aborted_q    <= 1'b0;
         dump_on_q    <= 1'b0;
         dump_deep_q  <= 1'b0;
         dump_start_q <= 1'b0;
         dump_stop_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         len_q        <= len_d;
         deep_q       <= deep_d;
         rem_q        <= rem_d;
         aborted_q    <= aborted_d;
         dump_on_q    <= dump_on_d;
         dump_deep_q  <= dump_deep_d;
         dump_start_q <= dump_start_d;
         dump_stop_q  <= dump_stop_d;
         busy_q       <= busy_d;
      end
   end

   // Priority in ARMED/DUMP: downloading, then arm low, then the frame tick.
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      len_d     = len_q;
      deep_d    = deep_q;
      rem_d     = rem_q;
      aborted_d = aborted_q;
      case (state_q)
         IDLE: begin
            if (cfg_we) begin
               start_d = cfg_start;
               len_d   = cfg_len;
               deep_d  = cfg_deep;
            end
            if (arm && !downloading) begin
               state_d   = ARMED;
               aborted_d = 1'b0;
            end
         end
         ARMED: begin
            if (downloading || !arm) begin
               state_d = IDLE;
            end else if (tick && (frame_cnt_w >= start_q)) begin
               state_d = DUMP;
               rem_d   = len_q;
            end
         end
         DUMP: begin
            if (downloading) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (!arm) begin
               state_d = IDLE;
            end else if (tick && (len_q != '0)) begin
               if (rem_q == LW'(1)) begin
                  state_d = DONE;
               end else begin
                  rem_d = rem_q - LW'(1);
               end
            end
         end
         DONE: begin
            if (!arm) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dump_on_d    = state_is_dump(state_d);
      dump_deep_d  = state_is_dump(state_d) & deep_q;
      dump_start_d = state_is_dump(state_d) & ~state_is_dump(state_q);
      dump_stop_d  = state_is_dump(state_q) & ~state_is_dump(state_d);
      busy_d       = state_is_busy(state_d);
   end

   assign frame_cnt  = frame_cnt_w;
   assign dump_on    = dump_on_q;
   assign dump_deep  = dump_deep_q;
   assign dump_start = dump_start_q;
   assign dump_stop  = dump_stop_q;
   assign aborted    = aborted_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Self-checking bench for jtframe_dump_ctrl: directed frame-window scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_jtframe_dump_ctrl;

   localparam int FW = 8;
   localparam int LW = 8;
   localparam int CNT_MOD = 256;
   localparam int S_IDLE = 0, S_ARMED = 1, S_DUMP = 2, S_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vs = 1'b0;
   logic          downloading = 1'b0;
   logic          cfg_we = 1'b0;
   logic [FW-1:0] cfg_start = '0;
   logic [LW-1:0] cfg_len = '0;
   logic          cfg_deep = 1'b0;
   logic          arm = 1'b0;
   logic [FW-1:0] frame_cnt;
   logic          dump_on, dump_deep, dump_start, dump_stop, aborted, busy;

   int vectors = 0;
   int miscompares = 0;

   jtframe_dump_ctrl #(.FW(FW), .LW(LW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vs          (vs),
      .downloading (downloading),
      .cfg_we      (cfg_we),
      .cfg_start   (cfg_start),
      .cfg_len     (cfg_len),
      .cfg_deep    (cfg_deep),
      .arm         (arm),
      .frame_cnt   (frame_cnt),
      .dump_on     (dump_on),
      .dump_deep   (dump_deep),
      .dump_start  (dump_start),
      .dump_stop   (dump_stop),
      .aborted     (aborted),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode, frame count modulo 2^FW, frames left in window.
   bit m_valid = 0;
   int m_mode, m_cnt, m_start, m_len, m_left;
   bit m_deep, m_ab, m_vs, p_start, p_stop;

   always @(posedge clk) begin
      int nxt;
      bit falling;
      if (!rst_n) begin
         m_valid = 1; m_mode = S_IDLE; m_cnt = 0; m_start = 0; m_len = 0;
         m_left = 0; m_deep = 0; m_ab = 0; m_vs = 0; p_start = 0; p_stop = 0;
      end else begin
         falling = m_vs && !vs;
         nxt = m_mode;
         if (m_mode == S_IDLE) begin
            if (cfg_we) begin m_start = cfg_start; m_len = cfg_len; m_deep = cfg_deep; end
            if (arm && !downloading) begin nxt = S_ARMED; m_ab = 0; end
         end else if (m_mode == S_ARMED) begin
            if (downloading || !arm) nxt = S_IDLE;
            else if (falling && m_cnt >= m_start) begin nxt = S_DUMP; m_left = m_len; end
         end else if (m_mode == S_DUMP) begin
            if (downloading) begin nxt = S_IDLE; m_ab = 1; end
            else if (!arm) nxt = S_IDLE;
            else if (falling && m_len != 0) begin
               m_left = m_left - 1;
               if (m_left == 0) nxt = S_DONE;
            end
         end else if (!arm) begin
            nxt = S_IDLE;
         end
         p_start = (nxt == S_DUMP) && (m_mode != S_DUMP);
         p_stop  = (m_mode == S_DUMP) && (nxt != S_DUMP);
         if (downloading) m_cnt = 0;
         else if (falling) m_cnt = (m_cnt + 1) % CNT_MOD;
         m_vs = vs;
         m_mode = nxt;
      end
   end

   int n_start = 0, n_stop = 0;
   int fc_at_start = -1, fc_at_stop = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance one clock; compare every output against the model each cycle.
   task automatic step();
      @(posedge clk);
      #1;
      if (m_valid) begin
         chk("frame_cnt",  64'(frame_cnt),  64'(m_cnt));
         chk("dump_on",    64'(dump_on),    64'(m_mode == S_DUMP));
         chk("dump_deep",  64'(dump_deep),  64'((m_mode == S_DUMP) && m_deep));
         chk("dump_start", 64'(dump_start), 64'(p_start));
         chk("dump_stop",  64'(dump_stop),  64'(p_stop));
         chk("aborted",    64'(aborted),    64'(m_ab));
         chk("busy",       64'(busy),       64'(m_mode == S_ARMED || m_mode == S_DUMP));
      end
      if (dump_start === 1'b1) begin n_start++; fc_at_start = int'(frame_cnt); end
      if (dump_stop === 1'b1) begin n_stop++; fc_at_stop = int'(frame_cnt); end
   endtask

   task automatic vs_fall();
      vs = 1'b1; step(); step();
      vs = 1'b0; step(); step();
   endtask

   task automatic quick_fall();
      vs = 1'b1; step();
      vs = 1'b0; step();
   endtask

   task automatic write_cfg(input int s, input int l, input bit d);
      cfg_we = 1'b1; cfg_start = FW'(s); cfg_len = LW'(l); cfg_deep = d;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      int s0, t0;
      rst_n = 1'b0;
      step(); step(); step();
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_aborted", 64'(aborted), 64'd0);
      rst_n = 1'b1;
      step();

      // start=3, len=2: opens on the tick with count 3, closes on count 5
      arm = 1'b1;
      write_cfg(3, 2, 0);
      chk("armed_busy", 64'(busy), 64'd1);
      repeat (6) vs_fall();
      chk("w1_starts", 64'(n_start), 64'd1);
      chk("w1_stops", 64'(n_stop), 64'd1);
      chk("w1_fc_start", 64'(fc_at_start), 64'd4);
      chk("w1_fc_stop", 64'(fc_at_stop), 64'd6);
      chk("w1_model_done", 64'(m_mode), 64'(S_DONE));
      chk("w1_busy_done", 64'(busy), 64'd0);
      vs_fall();
      chk("done_no_retrigger", 64'(n_start), 64'd1);

      // unbounded deep window closed by arm low
      arm = 1'b0; step();
      arm = 1'b1;
      write_cfg(0, 0, 1);
      vs_fall();
      chk("w2_deep", 64'(dump_deep), 64'd1);
      repeat (10) vs_fall();
      chk("w2_still_on", 64'(dump_on), 64'd1);
      arm = 1'b0; step();
      chk("w2_stop_pulse", 64'(dump_stop), 64'd1);
      chk("w2_off", 64'(dump_on), 64'd0);
      chk("w2_busy", 64'(busy), 64'd0);

      // download aborts a len=5 window in its second frame
      arm = 1'b1;
      write_cfg(0, 5, 0);
      vs_fall(); vs_fall();
      downloading = 1'b1; step();
      chk("ab_stop", 64'(dump_stop), 64'd1);
      chk("ab_aborted", 64'(aborted), 64'd1);
      chk("ab_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("ab_busy", 64'(busy), 64'd0);
      step();
      chk("ab_sticky", 64'(aborted), 64'd1);
      downloading = 1'b0; step();
      chk("rearm_clears", 64'(aborted), 64'd0);
      chk("rearm_busy", 64'(busy), 64'd1);

      // counter wrap, then start=2 triggers after the wrap
      arm = 1'b0; step();
      downloading = 1'b1; step();
      downloading = 1'b0;
      repeat (255) quick_fall();
      chk("wrap_max", 64'(frame_cnt), 64'd255);
      quick_fall();
      chk("wrap_zero", 64'(frame_cnt), 64'd0);
      arm = 1'b1;
      write_cfg(2, 1, 0);
      s0 = n_start;
      quick_fall(); quick_fall();
      chk("wrap_not_yet", 64'(n_start), 64'(s0));
      quick_fall();
      chk("wrap_trigger", 64'(n_start), 64'(s0 + 1));
      chk("wrap_fc_start", 64'(fc_at_start), 64'd3);
      quick_fall();
      chk("wrap_len1_done", 64'(dump_on), 64'd0);

      // configuration write during a window is ignored
      arm = 1'b0; step();
      arm = 1'b1;
      write_cfg(0, 3, 0);
      vs_fall();
      write_cfg(99, 7, 1);
      chk("cfg_ign_deep", 64'(dump_deep), 64'd0);
      chk("cfg_ign_on", 64'(dump_on), 64'd1);
      chk("cfg_ign_model", 64'(m_start), 64'd0);
      t0 = n_stop;
      vs_fall(); vs_fall();
      chk("cfg_ign_len_run", 64'(n_stop), 64'(t0));
      vs_fall();
      chk("cfg_ign_len_end", 64'(n_stop), 64'(t0 + 1));
      arm = 1'b0; step();
      arm = 1'b1; step();
      vs_fall();
      chk("cfg_ign_start", 64'(dump_on), 64'd1);

      // reset in the middle of a window
      rst_n = 1'b0; step();
      chk("mid_rst_on", 64'(dump_on), 64'd0);
      chk("mid_rst_stop", 64'(dump_stop), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_fc", 64'(frame_cnt), 64'd0);
      rst_n = 1'b1; step();

      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 2) == 0) vs = ~vs;
         arm = ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0;
         downloading = ($urandom_range(0, 149) == 0);
         rst_n = ($urandom_range(0, 799) != 0);
         cfg_we = ($urandom_range(0, 7) == 0);
         cfg_start = FW'($urandom_range(0, 24));
         cfg_len = LW'($urandom_range(0, 4));
         cfg_deep = 1'($urandom_range(0, 1));
         step();
      end
      rst_n = 1'b1; cfg_we = 1'b0; downloading = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jtframe_dump_ctrl.md
JTFRAME_DUMP_CTRL -- requirements
Module: jtframe_dump_ctrl

Interface
REQ-001 SHALL have parameter FW, default 32, frame counter width.
REQ-002 SHALL have parameter LW, default 16, dump window length width.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port vs  in  1  vertical sync, synchronous to clk; a frame boundary is its falling edge.
REQ-006 SHALL have port downloading  in  1  ROM download in progress; high suppresses frame counting and dumping.
REQ-007 SHALL have port cfg_we  in  1  write strobe for cfg_start/cfg_len/cfg_deep.
REQ-008 SHALL have ports cfg_start  in  FW, cfg_len  in  LW, cfg_deep  in  1  start frame, window length in frames (0 = unbounded), deep-dump select.
REQ-009 SHALL have port arm  in  1  level; high requests a capture.
REQ-010 SHALL have ports frame_cnt  out  FW, dump_on  out  1, dump_deep  out  1, dump_start  out  1, dump_stop  out  1, aborted  out  1, busy  out  1.

Function
REQ-011 SHALL register vs once; tick = previous vs high AND current vs low, one clk wide.
REQ-012 SHALL hold frame_cnt at 0 while downloading=1; otherwise increment by 1 on each tick, wrapping from 2^FW-1 to 0.
REQ-013 SHALL accept cfg_we only in IDLE, latching all three cfg fields in one cycle; cfg_we in any other state is ignored.
REQ-014 SHALL implement states IDLE, ARMED, DUMP, DONE.
REQ-015 IDLE -> ARMED when arm=1 and downloading=0; cfg_we in that cycle takes effect first.
REQ-016 ARMED -> DUMP on a tick where downloading=0 and frame_cnt (value before increment) >= latched start; start=0 therefore triggers on the first tick.
REQ-017 ARMED -> IDLE when arm=0; arm=0 takes priority over a simultaneous tick.
REQ-018 On entering DUMP: remaining counter loaded with latched len; dump_start pulses high for exactly one clk, in the first cycle of DUMP.
REQ-019 In DUMP, each tick decrements remaining if latched len != 0; the tick on which remaining == 1 moves to DONE and pulses dump_stop for one clk.
REQ-020 len=0: DUMP persists until arm=0 or abort; arm=0 in DUMP -> IDLE with one dump_stop pulse.
REQ-021 downloading rising in ARMED or DUMP -> IDLE; if from DUMP, dump_stop pulses and aborted is set; downloading beats tick and arm in the same cycle.
REQ-022 aborted SHALL stay high until the next IDLE -> ARMED transition.
REQ-023 DONE -> IDLE when arm=0; DONE never re-triggers while arm stays high.
REQ-024 dump_on SHALL be high exactly while state is DUMP; dump_deep = dump_on AND latched deep.
REQ-025 busy SHALL be high in ARMED and DUMP.
REQ-026 All outputs SHALL be registered; state-change latency one clk from the causing input/tick.

Reset
REQ-027 rst_n=0 at a rising clk SHALL force IDLE, frame_cnt=0, latched start=0, len=0, deep=0, remaining=0, all 1-bit outputs 0, vs register 0; applies mid-dump with no dump_stop pulse.

Structure
REQ-028 State encoding and the IDLE/ARMED/DUMP/DONE constants SHALL live in the shared jtframe package for reuse by sim monitors.
REQ-029 The vs edge detector plus frame counter SHALL be one sub-module, jtframe_frame_cnt (ports clk, rst_n, vs, downloading, tick, frame_cnt).

Verification
REQ-030 cfg start=3,len=2,arm=1, 6 vs falls -> dump_start one cycle after tick with frame_cnt 3, dump_on for 2 frames, dump_stop after tick with frame_cnt 5, state DONE.
REQ-031 cfg start=0,len=0,deep=1, arm=1 -> dump on first tick, dump_deep=1; arm=0 after 10 frames -> dump_stop pulse, IDLE.
REQ-032 Dumping with len=5, downloading=1 at frame 2 of window -> dump_stop, aborted=1, frame_cnt=0; re-arm clears aborted.
REQ-033 frame_cnt forced near 2^FW-1 (FW=4: 15) -> next tick reads 0; armed start=2 triggers when count reaches 2 after wrap.
REQ-034 cfg_we while DUMP with new start=99 -> no change to running window or latched start.
REQ-035 rst_n=0 one cycle during DUMP -> all outputs 0 next cycle, no dump_stop, IDLE.
